// File: rtl/arb_out_fifo.sv
// Output FIFO behind the 3-input arbiter: absorbs bursts from a stream with no
// backpressure and presents a first-word-fall-through valid/ready interface.
module arb_out_fifo #(
    parameter int WORD_BITS  = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_BITS-1:0]  iSnk0Data,
    input  logic                  iSnk0Valid,
    output logic [WORD_BITS-1:0]  oSrc0Data,
    output logic                  oSrc0Valid,
    input  logic                  iSrc0Ready,
    output logic [DEPTH_LOG2:0]   oCount,
    output logic                  oFull,
    output logic                  oOvf,
    input  logic                  iOvfClr
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WORD_BITS-1:0]  mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]   count_reg, count_next;
    logic                  valid_reg, valid_next;
    logic                  full_reg, full_next;
    logic                  ovf_reg, ovf_next;
    logic [WORD_BITS-1:0]  head_reg, head_next;

    logic pop, push_ok, drop;

    always_comb begin
        pop         = valid_reg & iSrc0Ready;
        push_ok     = iSnk0Valid & (~full_reg | pop);
        drop        = iSnk0Valid & ~push_ok;

        wr_ptr_next = push_ok ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

        count_next  = count_reg;
        if (push_ok && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !push_ok)
            count_next = count_reg - 1'b1;

        valid_next  = (count_next != '0);
        full_next   = (count_next == DEPTH_CNT);

        // Registered head read: if nothing older survives this edge, the new
        // head is the word being written right now, so bypass the array.
        head_next   = head_reg;
        if (count_reg == {{DEPTH_LOG2{1'b0}}, pop}) begin
            if (push_ok)
                head_next = iSnk0Data;
        end else begin
            head_next = mem[rd_ptr_next];
        end

        // A drop in the same cycle as a clear leaves the flag set.
        ovf_next    = drop | (ovf_reg & ~iOvfClr);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= iSnk0Data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            full_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            valid_reg  <= valid_next;
            full_reg   <= full_next;
            ovf_reg    <= ovf_next;
            head_reg   <= head_next;
        end
    end

    assign oSrc0Data  = head_reg;
    assign oSrc0Valid = valid_reg;
    assign oCount     = count_reg;
    assign oFull      = full_reg;
    assign oOvf       = ovf_reg;

endmodule

// File: tb/tb_arb_out_fifo.sv
// Directed bench for arb_out_fifo: reset, fill/drain, overflow, full push+pop,
// streaming wrap-around and a toggling-ready backpressure pattern.
module tb_arb_out_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [3:0]  count;
    logic        full;
    logic        ovf;
    logic        ovf_clr;

    int n_cmp = 0;
    int n_err = 0;

    arb_out_fifo #(.WORD_BITS(32), .DEPTH_LOG2(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .iSnk0Data  (snk_data),
        .iSnk0Valid (snk_valid),
        .oSrc0Data  (src_data),
        .oSrc0Valid (src_valid),
        .iSrc0Ready (src_ready),
        .oCount     (count),
        .oFull      (full),
        .oOvf       (ovf),
        .iOvfClr    (ovf_clr)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        snk_valid = 1'b0;
        src_ready = 1'b0;
        ovf_clr   = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic fill_1_to_8();
        src_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            snk_valid = 1'b1;
            snk_data  = 32'(i);
            step();
        end
        snk_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (count !== 4'd0 || src_valid !== 1'b0 || full !== 1'b0 || ovf !== 1'b0 || src_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: count=%0d valid=%b full=%b ovf=%b data=%h required 0/0/0/0/0",
                     count, src_valid, full, ovf, src_data);
        end
        $display("test_reset: count=%0d valid=%b", count, src_valid);
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 3; i++) begin
            snk_valid = 1'b1;
            snk_data  = 32'(16 + i);
            step();
        end
        n_cmp++;
        if (count !== 4'd3) begin
            n_err++;
            $display("FAIL pre_reset_count: got %0d want 3", count);
        end
        rst       = 1'b1;
        snk_data  = 32'hAA;
        src_ready = 1'b1;
        step();
        rst       = 1'b0;
        snk_valid = 1'b0;
        src_ready = 1'b0;
        n_cmp++;
        if (count !== 4'd0 || src_valid !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: count=%0d valid=%b ovf=%b want 0/0/0", count, src_valid, ovf);
        end
        snk_valid = 1'b1;
        snk_data  = 32'h5;
        step();
        snk_valid = 1'b0;
        n_cmp++;
        if (src_valid !== 1'b1 || src_data !== 32'h5 || count !== 4'd1) begin
            n_err++;
            $display("FAIL push_after_reset: valid=%b data=%h count=%0d want 1/5/1", src_valid, src_data, count);
        end
        src_ready = 1'b1;
        step();
        src_ready = 1'b0;
        n_cmp++;
        if (src_valid !== 1'b0 || count !== 4'd0) begin
            n_err++;
            $display("FAIL drain_after_reset: valid=%b count=%0d want 0/0", src_valid, count);
        end
        $display("test_reset_mid: done");
    endtask

    task automatic test_fill_drain();
        idle();
        fill_1_to_8();
        n_cmp++;
        if (full !== 1'b1 || count !== 4'd8 || src_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fill: full=%b count=%0d valid=%b want 1/8/1", full, count, src_valid);
        end
        src_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if (src_valid !== 1'b1 || src_data !== 32'(i)) begin
                n_err++;
                $display("FAIL drain_word: valid=%b data=%0d want 1/%0d", src_valid, src_data, i);
            end
            step();
        end
        src_ready = 1'b0;
        n_cmp++;
        if (src_valid !== 1'b0 || count !== 4'd0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL drained: valid=%b count=%0d full=%b want 0/0/0", src_valid, count, full);
        end
        $display("test_fill_drain: done");
    endtask

    task automatic test_overflow();
        idle();
        fill_1_to_8();
        snk_valid = 1'b1;
        snk_data  = 32'd9;
        step();
        snk_valid = 1'b0;
        n_cmp++;
        if (ovf !== 1'b1 || count !== 4'd8 || src_data !== 32'd1) begin
            n_err++;
            $display("FAIL overflow_set: ovf=%b count=%0d head=%0d want 1/8/1", ovf, count, src_data);
        end
        // Drop and clear together: the set must win.
        snk_valid = 1'b1;
        snk_data  = 32'd10;
        ovf_clr   = 1'b1;
        step();
        snk_valid = 1'b0;
        ovf_clr   = 1'b0;
        n_cmp++;
        if (ovf !== 1'b1 || count !== 4'd8) begin
            n_err++;
            $display("FAIL drop_vs_clear: ovf=%b count=%0d want 1/8", ovf, count);
        end
        src_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if (src_valid !== 1'b1 || src_data !== 32'(i)) begin
                n_err++;
                $display("FAIL ovf_drain_word: valid=%b data=%0d want 1/%0d", src_valid, src_data, i);
            end
            step();
        end
        src_ready = 1'b0;
        n_cmp++;
        if (src_valid !== 1'b0 || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_after_drain: valid=%b ovf=%b want 0/1", src_valid, ovf);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: ovf=%b want 0", ovf);
        end
        $display("test_overflow: done");
    endtask

    task automatic test_full_push_pop();
        idle();
        fill_1_to_8();
        src_ready = 1'b1;
        snk_valid = 1'b1;
        snk_data  = 32'd9;
        step();
        snk_valid = 1'b0;
        n_cmp++;
        if (count !== 4'd8 || ovf !== 1'b0 || full !== 1'b1 || src_data !== 32'd2) begin
            n_err++;
            $display("FAIL full_push_pop: count=%0d ovf=%b full=%b head=%0d want 8/0/1/2",
                     count, ovf, full, src_data);
        end
        for (int i = 2; i <= 9; i++) begin
            n_cmp++;
            if (src_valid !== 1'b1 || src_data !== 32'(i)) begin
                n_err++;
                $display("FAIL fpp_drain_word: valid=%b data=%0d want 1/%0d", src_valid, src_data, i);
            end
            step();
        end
        src_ready = 1'b0;
        n_cmp++;
        if (src_valid !== 1'b0 || count !== 4'd0) begin
            n_err++;
            $display("FAIL fpp_drained: valid=%b count=%0d want 0/0", src_valid, count);
        end
        $display("test_full_push_pop: done");
    endtask

    task automatic test_stream();
        idle();
        src_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            snk_valid = 1'b1;
            snk_data  = 32'(i);
            step();
            n_cmp++;
            if (src_valid !== 1'b1 || src_data !== 32'(i) || count !== 4'd1 || ovf !== 1'b0) begin
                n_err++;
                $display("FAIL stream_word: valid=%b data=%0d count=%0d ovf=%b want 1/%0d/1/0",
                         src_valid, src_data, count, ovf, i);
            end
        end
        snk_valid = 1'b0;
        step();
        src_ready = 1'b0;
        n_cmp++;
        if (src_valid !== 1'b0 || count !== 4'd0) begin
            n_err++;
            $display("FAIL stream_end: valid=%b count=%0d want 0/0", src_valid, count);
        end
        $display("test_stream: done");
    endtask

    // Ready toggles 1,0,1,0 starting at cycle 0 with a push every cycle. Cycle 0
    // cannot pop (empty), so after cycle k the count is (k+1)/2+1, capped at 8.
    // Cycle 14 pops and pushes while full; cycle 15 is the first dropped push.
    task automatic test_backpressure();
        int exp_cnt;
        idle();
        for (int k = 0; k < 16; k++) begin
            snk_valid = 1'b1;
            snk_data  = 32'(4 * (k + 1));
            src_ready = (k % 2 == 0);
            if (k >= 2 && k % 2 == 0) begin
                n_cmp++;
                if (src_valid !== 1'b1 || src_data !== 32'(4 * (k / 2))) begin
                    n_err++;
                    $display("FAIL bp_pop_word: cycle %0d valid=%b data=%h want 1/%h",
                             k, src_valid, src_data, 4 * (k / 2));
                end
            end
            step();
            exp_cnt = (k + 1) / 2 + 1;
            if (exp_cnt > 8)
                exp_cnt = 8;
            n_cmp++;
            if (count !== 4'(exp_cnt) || ovf !== (k == 15)) begin
                n_err++;
                $display("FAIL bp_state: cycle %0d count=%0d ovf=%b want %0d/%b",
                         k, count, ovf, exp_cnt, (k == 15));
            end
        end
        snk_valid = 1'b0;
        src_ready = 1'b1;
        // Remaining words: pops so far took 4..28 (cycles 2..14), so 32..60 remain.
        for (int i = 8; i <= 15; i++) begin
            n_cmp++;
            if (src_valid !== 1'b1 || src_data !== 32'(4 * i)) begin
                n_err++;
                $display("FAIL bp_drain_word: valid=%b data=%h want 1/%h", src_valid, src_data, 4 * i);
            end
            step();
        end
        n_cmp++;
        if (src_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drained: valid=%b want 0", src_valid);
        end
        src_ready = 1'b0;
        $display("test_backpressure: done");
    endtask

    initial begin
        snk_data = '0;
        idle();
        rst = 1'b1;
        test_reset();
        test_reset_mid();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_stream();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
